// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller: FSM state encoding,
// transaction direction codes and default slot geometry.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OPEN  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic DIR_ENTER = 1'b1;
    localparam logic DIR_EXIT  = 1'b0;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int SLOT_W_DEF    = 2;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational priority encoder: reports the lowest-index free (0) slot.
module free_slot_finder
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_W    = SLOT_W_DEF
) (
    input  logic [NUM_SLOTS-1:0] occupied,
    output logic                 found,
    output logic [SLOT_W-1:0]    idx
);

    // Scan downward so the last hit, and therefore the winner, is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                found = 1'b1;
                idx   = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Sequences barrier gate and SlotManager updates: arbitrates entry/exit,
// opens the gate, and commits the slot change only once the car has passed.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a request; arbitrates and accepts or rejects
// ST_GRANT | ack pulse cycle; direction and slot already latched
// ST_OPEN  | gate open, waiting for car_passed or pass timeout
// ST_GUARD | gate closed, hold-off before the next request is accepted
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS    = NUM_SLOTS_DEF,
    parameter int SLOT_W       = SLOT_W_DEF,
    parameter int PASS_TIMEOUT = 200,
    parameter int CLOSE_GUARD  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    input  logic [NUM_SLOTS-1:0] slot_status,
    input  logic                 car_passed,
    output logic                 entry_ack,
    output logic                 exit_ack,
    output logic                 reject,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 upd_valid,
    output logic [SLOT_W-1:0]    upd_slot,
    output logic                 upd_enter,
    output logic                 gate_open,
    output logic                 timeout,
    output logic                 busy
);

    localparam int CNT_MAX = (PASS_TIMEOUT > CLOSE_GUARD) ? PASS_TIMEOUT : CLOSE_GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rr_last;
    logic               dir_lat;
    logic [SLOT_W-1:0]  slot_lat;

    logic               free_found;
    logic [SLOT_W-1:0]  free_idx;
    logic               pick_entry;

    free_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_free_slot_finder (
        .occupied (slot_status),
        .found    (free_found),
        .idx      (free_idx)
    );

    // On a tie, serve whichever side was not served last.
    assign pick_entry = entry_req && (!exit_req || (rr_last == DIR_EXIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rr_last       <= DIR_EXIT;
            dir_lat       <= DIR_EXIT;
            slot_lat      <= '0;
            entry_ack     <= 1'b0;
            exit_ack      <= 1'b0;
            reject        <= 1'b0;
            assigned_slot <= '0;
            upd_valid     <= 1'b0;
            upd_slot      <= '0;
            upd_enter     <= 1'b0;
            gate_open     <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            entry_ack <= 1'b0;
            exit_ack  <= 1'b0;
            reject    <= 1'b0;
            upd_valid <= 1'b0;
            timeout   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_entry) begin
                        if (free_found) begin
                            state         <= ST_GRANT;
                            busy          <= 1'b1;
                            entry_ack     <= 1'b1;
                            assigned_slot <= free_idx;
                            slot_lat      <= free_idx;
                            dir_lat       <= DIR_ENTER;
                            rr_last       <= DIR_ENTER;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (exit_req) begin
                        if (slot_status[exit_slot]) begin
                            state    <= ST_GRANT;
                            busy     <= 1'b1;
                            exit_ack <= 1'b1;
                            slot_lat <= exit_slot;
                            dir_lat  <= DIR_EXIT;
                            rr_last  <= DIR_EXIT;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end

                ST_GRANT: begin
                    state     <= ST_OPEN;
                    gate_open <= 1'b1;
                    cnt       <= CNT_W'(PASS_TIMEOUT - 1);
                end

                ST_OPEN: begin
                    // car_passed takes priority over an expiring counter.
                    if (car_passed) begin
                        upd_valid <= 1'b1;
                        upd_slot  <= slot_lat;
                        upd_enter <= dir_lat;
                        gate_open <= 1'b0;
                        state     <= ST_GUARD;
                        cnt       <= CNT_W'(CLOSE_GUARD - 1);
                    end else if (cnt == '0) begin
                        timeout   <= 1'b1;
                        gate_open <= 1'b0;
                        state     <= ST_GUARD;
                        cnt       <= CNT_W'(CLOSE_GUARD - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_GUARD: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    gate_open <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller: a transaction-level model predicts
// every output pulse (kind, cycle, slot) and a monitor compares what the DUT presents.
module tb_parking_gate_controller;

    localparam int NUM_SLOTS    = 4;
    localparam int SLOT_W       = 2;
    localparam int PASS_TIMEOUT = 200;
    localparam int CLOSE_GUARD  = 8;

    localparam logic [4:0] P_EACK = 5'b10000;
    localparam logic [4:0] P_XACK = 5'b01000;
    localparam logic [4:0] P_REJ  = 5'b00100;
    localparam logic [4:0] P_UPD  = 5'b00010;
    localparam logic [4:0] P_TO   = 5'b00001;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 entry_req;
    logic                 exit_req;
    logic [SLOT_W-1:0]    exit_slot;
    logic [NUM_SLOTS-1:0] slot_status;
    logic                 car_passed;
    logic                 entry_ack;
    logic                 exit_ack;
    logic                 reject;
    logic [SLOT_W-1:0]    assigned_slot;
    logic                 upd_valid;
    logic [SLOT_W-1:0]    upd_slot;
    logic                 upd_enter;
    logic                 gate_open;
    logic                 timeout;
    logic                 busy;

    parking_gate_controller #(
        .NUM_SLOTS    (NUM_SLOTS),
        .SLOT_W       (SLOT_W),
        .PASS_TIMEOUT (PASS_TIMEOUT),
        .CLOSE_GUARD  (CLOSE_GUARD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .slot_status   (slot_status),
        .car_passed    (car_passed),
        .entry_ack     (entry_ack),
        .exit_ack      (exit_ack),
        .reject        (reject),
        .assigned_slot (assigned_slot),
        .upd_valid     (upd_valid),
        .upd_slot      (upd_slot),
        .upd_enter     (upd_enter),
        .gate_open     (gate_open),
        .timeout       (timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                c;
        logic [4:0]        pulses;
        logic [SLOT_W-1:0] slot;
        logic              enter;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Model state: first cycle the DUT may accept a request, and who was served last.
    int  idle_from;
    bit  last_entry;

    function automatic void check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endfunction

    function automatic void push(input int c, input logic [4:0] p, input int s, input bit en);
        ev_t e;
        e.c      = c;
        e.pulses = p;
        e.slot   = SLOT_W'(s);
        e.enter  = en;
        exp_q.push_back(e);
    endfunction

    function automatic int lowest_free(input logic [NUM_SLOTS-1:0] occ);
        for (int i = 0; i < NUM_SLOTS; i++)
            if (!occ[i]) return i;
        return -1;
    endfunction

    task automatic wait_cyc(input int x);
        while (cyc < x) @(negedge clk);
    endtask

    // Monitor: whenever any pulse output is high, pop and compare one expected event.
    initial begin
        ev_t        e;
        logic [4:0] obs;
        forever begin
            @(negedge clk);
            obs = {entry_ack, exit_ack, reject, upd_valid, timeout};
            if (reset === 1'b1 && obs != 5'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got pulses %b required none (cyc %0d)", obs, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_pulses", int'(obs), int'(e.pulses));
                    check("event_cycle", cyc, e.c);
                    if (e.pulses == P_EACK) check("assigned_slot", int'(assigned_slot), int'(e.slot));
                    if (e.pulses == P_UPD) begin
                        check("upd_slot", int'(upd_slot), int'(e.slot));
                        check("upd_enter", int'(upd_enter), int'(e.enter));
                    end
                end
            end
        end
    end

    // One customer transaction set: requests held until the model says they are answered.
    task automatic run_txn(input bit want_en, input bit want_ex, input logic [NUM_SLOTS-1:0] occ,
                           input logic [SLOT_W-1:0] xs, input int d_en, input int d_ex);
        bit pe, px, pick_en, ok;
        int k, slot, d, e_cyc, q;
        wait_cyc(idle_from - 1);
        slot_status = occ;
        exit_slot   = xs;
        entry_req   = want_en;
        exit_req    = want_ex;
        pe = want_en;
        px = want_ex;
        while (pe || px) begin
            if (cyc + 1 < idle_from) wait_cyc(idle_from - 1);
            k = cyc + 1;
            pick_en = pe && (!px || !last_entry);
            if (pick_en) begin
                slot = lowest_free(occ);
                ok   = (slot >= 0);
            end else begin
                slot = int'(xs);
                ok   = occ[xs];
            end
            if (!ok) begin
                push(k, P_REJ, 0, 0);
                wait_cyc(k);
                if (pick_en) begin entry_req = 1'b0; pe = 1'b0; end
                else begin exit_req = 1'b0; px = 1'b0; end
                check("busy_on_reject", int'(busy), 0);
                check("gate_on_reject", int'(gate_open), 0);
            end else begin
                push(k, pick_en ? P_EACK : P_XACK, slot, 1'b0);
                d = pick_en ? d_en : d_ex;
                if (d < PASS_TIMEOUT) begin
                    e_cyc = k + 2 + d;
                    push(e_cyc, P_UPD, slot, pick_en);
                end else begin
                    e_cyc = k + 1 + PASS_TIMEOUT;
                    push(e_cyc, P_TO, 0, 1'b0);
                end
                last_entry = pick_en;
                wait_cyc(k);
                check("gate_closed_at_ack", int'(gate_open), 0);
                check("busy_at_ack", int'(busy), 1);
                if (pick_en) begin entry_req = 1'b0; pe = 1'b0; end
                else begin exit_req = 1'b0; px = 1'b0; end
                wait_cyc(k + 1);
                check("gate_open_after_ack", int'(gate_open), 1);
                q = k + 1 + d;
                if (q <= e_cyc + 6) begin
                    wait_cyc(q);
                    car_passed = 1'b1;
                    wait_cyc(q + 1);
                    car_passed = 1'b0;
                end
                wait_cyc(e_cyc);
                check("gate_closed_after_txn", int'(gate_open), 0);
                wait_cyc(e_cyc + CLOSE_GUARD - 1);
                check("busy_in_guard", int'(busy), 1);
                wait_cyc(e_cyc + CLOSE_GUARD);
                check("busy_back_idle", int'(busy), 0);
                idle_from = e_cyc + CLOSE_GUARD + 1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset       = 1'b0;
        entry_req   = 1'b0;
        exit_req    = 1'b0;
        exit_slot   = '0;
        slot_status = '0;
        car_passed  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({entry_ack, exit_ack, reject, upd_valid, upd_slot, upd_enter,
                                     gate_open, timeout, busy, assigned_slot}), 0);
        reset      = 1'b1;
        last_entry = 1'b0;
        idle_from  = cyc + 1;

        // Directed: tie with entry first, plain entry, full lot, bad exit, timeout, late-car boundary.
        run_txn(1'b1, 1'b1, 4'b0101, 2'd2, 4, 2);
        run_txn(1'b1, 1'b0, 4'b0000, 2'd0, 5, 0);
        run_txn(1'b1, 1'b0, 4'b1111, 2'd0, 0, 0);
        run_txn(1'b0, 1'b1, 4'b0111, 2'd3, 0, 0);
        run_txn(1'b1, 1'b0, 4'b0001, 2'd0, PASS_TIMEOUT + 3, 0);
        run_txn(1'b0, 1'b1, 4'b1000, 2'd3, PASS_TIMEOUT - 1, 0);

        for (int n = 0; n < 30; n++) begin
            logic [NUM_SLOTS-1:0] occ;
            int sel, den, dex;
            occ = ($urandom_range(0, 4) == 0) ? 4'b1111 : NUM_SLOTS'($urandom);
            sel = $urandom_range(0, 2);
            den = ($urandom_range(0, 9) == 0) ? $urandom_range(PASS_TIMEOUT, PASS_TIMEOUT + 6)
                                              : $urandom_range(0, 15);
            dex = ($urandom_range(0, 9) == 0) ? $urandom_range(PASS_TIMEOUT, PASS_TIMEOUT + 6)
                                              : $urandom_range(0, 15);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(sel != 1, sel != 0, occ, SLOT_W'($urandom), den, dex);
        end

        // Reset while the gate is open: closes at once, no update, entry wins the next tie.
        wait_cyc(idle_from - 1);
        slot_status = 4'b0000;
        entry_req   = 1'b1;
        k = cyc + 1;
        push(k, P_EACK, 0, 1'b0);
        wait_cyc(k);
        entry_req = 1'b0;
        wait_cyc(k + 4);
        check("gate_open_before_reset", int'(gate_open), 1);
        reset = 1'b0;
        #1;
        check("gate_async_close", int'(gate_open), 0);
        check("busy_async_clear", int'(busy), 0);
        car_passed = 1'b1;
        repeat (3) @(negedge clk);
        car_passed = 1'b0;
        check("outputs_in_reset", int'({entry_ack, exit_ack, reject, upd_valid, upd_slot, upd_enter,
                                        gate_open, timeout, busy, assigned_slot}), 0);
        reset      = 1'b1;
        last_entry = 1'b0;
        idle_from  = cyc + 1;
        run_txn(1'b1, 1'b1, 4'b0010, 2'd1, 3, 4);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
